load_store_unit: RTL and testbench

//  Executes RV32I loads/stores issued by the decoder/ALU path: consumes request/type/we/sign-ext

---
 rtl/toothless_pkg.sv | 43 ++++
 rtl/lsu_rdata_align.sv | 27 ++
 rtl/load_store_unit.sv | 99 +++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toothless_pkg.sv
// Shared LSU types plus the access-size helpers used to validate requests and
// to build the byte-enable and write-data lanes.
package toothless_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_GNT,
    LSU_WAIT_RVALID
  } lsu_state_e;

  // Type 2'b11 is not a legal access size, so it is reported as misaligned.
  function automatic logic lsu_aligned(input logic [1:0] size_type, input logic [1:0] offset);
    case (size_type)
      LSU_BYTE: return 1'b1;
      LSU_HALF: return ~offset[0];
      LSU_WORD: return offset == 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [1:0] size_type, input logic [1:0] offset);
    case (size_type)
      LSU_BYTE: return 4'b0001 << offset;
      LSU_HALF: return 4'b0011 << offset;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [1:0] size_type, input logic [31:0] wdata);
    case (size_type)
      LSU_BYTE: return {4{wdata[7:0]}};
      LSU_HALF: return {2{wdata[15:0]}};
      default:  return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Selects the addressed byte/half lane from a read word and extends it to
// 32 bits.
module lsu_rdata_align
  import toothless_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size_type,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = rdata[{offset[1], 4'b0000} +: 16];
    data      = rdata;
    case (size_type)
      LSU_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      LSU_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates the request, drives one OBI req/gnt/rvalid
// transaction and returns the aligned, extended load data.
module load_store_unit
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [1:0]              lsu_type_i,
  input  logic                    lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_busy_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  output logic                    lsu_misaligned_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i
);

  lsu_state_e      state, state_next;
  logic            aligned, accept, done;
  logic [1:0]      offset_q, type_q;
  logic            sign_ext_q;
  logic [31:0]     load_data;

  assign aligned = lsu_aligned(lsu_type_i, lsu_addr_i[1:0]);
  assign accept  = (state == LSU_IDLE) && lsu_req_i && aligned;
  assign done    = (state == LSU_WAIT_RVALID) && data_rvalid_i;

  always_comb begin
    state_next = state;
    data_req_o = 1'b0;
    lsu_busy_o = accept || (state != LSU_IDLE);
    case (state)
      LSU_IDLE:        if (accept) state_next = LSU_WAIT_GNT;
      LSU_WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_next = LSU_WAIT_RVALID;
      end
      LSU_WAIT_RVALID: if (data_rvalid_i) state_next = LSU_IDLE;
      default:         state_next = LSU_IDLE;
    endcase
  end

  lsu_rdata_align u_rdata_align (
    .rdata     (data_rdata_i),
    .offset    (offset_q),
    .size_type (type_q),
    .sign_ext  (sign_ext_q),
    .data      (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= LSU_IDLE;
      offset_q         <= '0;
      type_q           <= '0;
      sign_ext_q       <= 1'b0;
      data_addr_o      <= '0;
      data_we_o        <= 1'b0;
      data_be_o        <= '0;
      data_wdata_o     <= '0;
      lsu_rvalid_o     <= 1'b0;
      lsu_err_o        <= 1'b0;
      lsu_rdata_o      <= '0;
      lsu_misaligned_o <= 1'b0;
    end else begin
      state            <= state_next;
      lsu_misaligned_o <= (state == LSU_IDLE) && lsu_req_i && !aligned;
      lsu_rvalid_o     <= done;
      lsu_err_o        <= done && data_err_i;
      if (accept) begin
        offset_q     <= lsu_addr_i[1:0];
        type_q       <= lsu_type_i;
        sign_ext_q   <= lsu_sign_ext_i;
        data_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        data_we_o    <= lsu_we_i;
        data_be_o    <= lsu_be(lsu_type_i, lsu_addr_i[1:0]);
        data_wdata_o <= lsu_wdata(lsu_type_i, lsu_wdata_i);
      end
      // Stores and errored loads return zero so the core never sees stale bus data.
      if (done) lsu_rdata_o <= (data_we_o || data_err_i) ? '0 : load_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// misalignment sequences, then randomized transactions against a byte-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_rvalid_o, lsu_err_o, lsu_misaligned_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .lsu_misaligned_o(lsu_misaligned_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  t;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned gd;
    int unsigned rd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access viewed as `size` consecutive bytes starting at the offset.
  function automatic int size_of(input logic [1:0] t);
    return 1 << t;
  endfunction

  function automatic logic m_aligned(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'b11) return 1'b0;
    return (a % size_of(t)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] t, input logic [31:0] a);
    logic [3:0] be = '0;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + size_of(t)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] w);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % size_of(t)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] t, input logic sext, input logic [31:0] a,
                                          input logic [31:0] rdata, input logic we, input logic err);
    longint v, span;
    if (we || err) return '0;
    if (t == 2'b10) return rdata;
    span = longint'(1) << (8 * size_of(t));
    v = (longint'(rdata) >> (8 * (a % 4))) % span;
    if (sext && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [1:0] t, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err,
                         input int unsigned gd, input int unsigned rd,
                         input logic [3:0] be, input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = t; lsu_sign_ext_i = sext;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    #1;
    chk("accept_busy", 32'(lsu_busy_o), 32'd1);
    chk("accept_no_req", 32'(data_req_o), 32'd0);
    chk("rvalid_pulse_end", 32'(lsu_rvalid_o), 32'd0);
    for (int unsigned g = 0; g <= gd; g++) begin
      @(negedge clk);
      // Core is stalled: request-side inputs and stray responses must be ignored.
      lsu_req_i = 1'($urandom); lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
      lsu_type_i = 2'($urandom); lsu_we_i = 1'($urandom);
      data_gnt_i = (g == gd);
      data_rvalid_i = 1'($urandom); data_rdata_i = $urandom; data_err_i = 1'($urandom);
      #1;
      chk("gnt_req", 32'(data_req_o), 32'd1);
      chk("gnt_addr", data_addr_o, {addr[31:2], 2'b00});
      chk("gnt_be", 32'(data_be_o), 32'(be));
      chk("gnt_wdata", data_wdata_o, exp_wd);
      chk("gnt_we", 32'(data_we_o), 32'(we));
      chk("gnt_busy", 32'(lsu_busy_o), 32'd1);
      chk("gnt_no_rvalid", 32'(lsu_rvalid_o), 32'd0);
    end
    for (int unsigned r = 0; r <= rd; r++) begin
      @(negedge clk);
      data_gnt_i = 1'($urandom);
      data_rvalid_i = (r == rd);
      data_rdata_i = (r == rd) ? rdata : $urandom;
      data_err_i = (r == rd) ? err : 1'($urandom);
      #1;
      chk("rv_req_low", 32'(data_req_o), 32'd0);
      chk("rv_busy", 32'(lsu_busy_o), 32'd1);
      chk("rv_no_rvalid", 32'(lsu_rvalid_o), 32'd0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("done_rvalid", 32'(lsu_rvalid_o), 32'd1);
    chk("done_err", 32'(lsu_err_o), 32'(err));
    chk("done_rdata", lsu_rdata_o, exp_rd);
    chk("done_busy", 32'(lsu_busy_o), 32'd0);
    chk("done_mis", 32'(lsu_misaligned_o), 32'd0);
  endtask

  task automatic run_misaligned(input logic [1:0] t, input logic [31:0] addr);
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 1'($urandom); lsu_type_i = t; lsu_addr_i = addr;
    lsu_wdata_i = $urandom;
    #1;
    chk("mis_busy", 32'(lsu_busy_o), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_pulse", 32'(lsu_misaligned_o), 32'd1);
    chk("mis_no_req", 32'(data_req_o), 32'd0);
    chk("mis_no_rvalid", 32'(lsu_rvalid_o), 32'd0);
    @(negedge clk);
    #1;
    chk("mis_pulse_end", 32'(lsu_misaligned_o), 32'd0);
    chk("mis_still_idle", 32'(data_req_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //           we    t      sx    addr          wdata         rdata         err   gd rd mis   be       exp_wd        exp_rd
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 4'b1111, 32'h00000000, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h00000103, 32'h00000000, 32'h80FF0000, 1'b0, 0, 0, 1'b0, 4'b1000, 32'h00000000, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h00000103, 32'h00000000, 32'h80FF0000, 1'b0, 0, 0, 1'b0, 4'b1000, 32'h00000000, 32'h00000080};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h00000102, 32'h1234ABCD, 32'h55555555, 1'b0, 0, 1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h00000000};
    vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h00000200, 32'h11223344, 32'hFFFFFFFF, 1'b0, 3, 0, 1'b0, 4'b1111, 32'h11223344, 32'h00000000};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h00000102, 32'h00000000, 32'h80001234, 1'b1, 0, 2, 1'b0, 4'b1100, 32'h00000000, 32'h00000000};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h00000102, 32'h00000000, 32'h80001234, 1'b0, 1, 0, 1'b0, 4'b1100, 32'h00000000, 32'hFFFF8000};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h00000100, 32'h00000000, 32'h80009234, 1'b0, 0, 0, 1'b0, 4'b0011, 32'h00000000, 32'h00009234};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h00000101, 32'h000000A5, 32'h00000000, 1'b0, 2, 2, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h00000000};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h00000101, 32'h00000000, 32'h00007F00, 1'b0, 0, 0, 1'b0, 4'b0010, 32'h00000000, 32'h0000007F};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h00000101, 32'h00000000, 32'h00000000, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h00000103, 32'h00000000, 32'h00000000, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h00000100, 32'h00000000, 32'h00000000, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(data_req_o), 32'd0);
    chk("rst_busy", 32'(lsu_busy_o), 32'd0);
    chk("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    chk("rst_mis", 32'(lsu_misaligned_o), 32'd0);
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_be", 32'(data_be_o), 32'd0);
    chk("rst_wdata", data_wdata_o, 32'd0);
    chk("rst_we", 32'(data_we_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].mis) run_misaligned(vecs[i].t, vecs[i].addr);
      else run_txn(vecs[i].we, vecs[i].t, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].err, vecs[i].gd, vecs[i].rd,
                   vecs[i].be, vecs[i].exp_wd, vecs[i].exp_rd);
    end

    // Reset while waiting for rvalid, then a stray rvalid must not complete anything.
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_type_i = 2'b10; lsu_addr_i = 32'h00000300;
    @(negedge clk);
    idle_inputs();
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    #1;
    chk("rstmid_in_rvalid_wait", 32'(data_req_o), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    #1;
    chk("rstmid_req", 32'(data_req_o), 32'd0);
    chk("rstmid_busy", 32'(lsu_busy_o), 32'd0);
    @(negedge clk);
    data_rvalid_i = 1'b0;
    #1;
    chk("rstmid_no_rvalid", 32'(lsu_rvalid_o), 32'd0);
    chk("rstmid_rdata", lsu_rdata_o, 32'd0);
    @(negedge clk);
    #1;
    chk("rstmid_no_rvalid2", 32'(lsu_rvalid_o), 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  t    = 2'($urandom_range(0, 3));
      logic [31:0] addr = $urandom;
      logic        we   = 1'($urandom);
      logic        sext = 1'($urandom);
      logic [31:0] wd   = $urandom;
      logic [31:0] rdat = $urandom;
      logic        err  = ($urandom_range(0, 7) == 0);
      if (m_aligned(t, addr))
        run_txn(we, t, sext, addr, wd, rdat, err, $urandom_range(0, 3), $urandom_range(0, 3),
                m_be(t, addr), m_wdata(t, wd), m_rdata(t, sext, addr, rdat, we, err));
      else
        run_misaligned(t, addr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
